// File: rtl/timer_scheduler_pkg.sv
// Shared types and constants for the 1 Hz countdown scheduler.
package timer_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLookup,
    StRun,
    StDone
  } state_e;

  typedef enum logic {
    OwnerFsm  = 1'b0,
    OwnerWalk = 1'b1
  } owner_e;

  localparam logic [1:0] IntMainGreen = 2'd0;
  localparam logic [1:0] IntSideGreen = 2'd1;
  localparam logic [1:0] IntYellow    = 2'd2;
  localparam logic [1:0] IntWalk      = 2'd3;

endpackage

// File: rtl/timer_scheduler_countdown_core.sv
// Loadable down-counter; saturates at zero and flags expiry on the last tick.
module timer_scheduler_countdown_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             Reset_Sync_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             tick,
  output logic [WIDTH-1:0] remaining,
  output logic             expire
);

  logic [WIDTH-1:0] count_q, count_d;

  // Clear beats load beats tick: a pre-empted or cancelled count is simply dropped.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset_Sync_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A zero load expires immediately; otherwise expiry is the tick that takes 1 to 0.
  assign expire    = (count_q == '0) || (tick && (count_q == WIDTH'(1)));
  assign remaining = count_q;

endmodule

// File: rtl/timer_scheduler.sv
// Arbitrates the shared 1 Hz countdown between the light FSM (priority) and the walk display.
module timer_scheduler
  import timer_scheduler_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned LOOKUP_LAT = 1
) (
  input  logic             clk,
  input  logic             Reset_Sync_n,
  input  logic             oneHz_enable,
  input  logic             req0,
  input  logic [1:0]       int0,
  input  logic             req1,
  input  logic [1:0]       int1,
  input  logic [WIDTH-1:0] value_in,
  output logic [1:0]       interval_out,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             abort1,
  output logic [WIDTH-1:0] remaining,
  output logic             busy
);

  localparam logic [1:0] LatLast = 2'(LOOKUP_LAT - 1);

  state_e     state_q, state_d;
  owner_e     owner_q, owner_d;
  logic [1:0] lat_q, lat_d;
  logic [1:0] ival_q, ival_d;

  logic       req_own, preempt, load, clear, dec, expire;
  logic       busy_d, gnt0_d, gnt1_d, done0_d, done1_d, abort1_d;
  logic [1:0] ival_out_d;

  assign req_own = (owner_q == OwnerFsm) ? req0 : req1;
  assign dec     = (state_q == StRun) && oneHz_enable;

  always_ff @(posedge clk) begin
    if (!Reset_Sync_n) begin
      state_q      <= StIdle;
      owner_q      <= OwnerFsm;
      lat_q        <= '0;
      ival_q       <= IntMainGreen;
      interval_out <= IntMainGreen;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      abort1       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lat_q        <= lat_d;
      ival_q       <= ival_d;
      interval_out <= ival_out_d;
      gnt0         <= gnt0_d;
      gnt1         <= gnt1_d;
      done0        <= done0_d;
      done1        <= done1_d;
      abort1       <= abort1_d;
      busy         <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    lat_d   = lat_q;
    ival_d  = ival_q;
    load    = 1'b0;
    clear   = 1'b0;
    preempt = 1'b0;
    unique case (state_q)
      StIdle: begin
        clear = 1'b1;
        if (req0) begin
          state_d = StLookup;
          owner_d = OwnerFsm;
          ival_d  = int0;
          lat_d   = '0;
        end else if (req1) begin
          state_d = StLookup;
          owner_d = OwnerWalk;
          ival_d  = int1;
          lat_d   = '0;
        end
      end
      StLookup, StRun: begin
        if ((owner_q == OwnerWalk) && req0) begin
          // Light FSM takes over; the walk count and any coincident tick are dropped.
          preempt = 1'b1;
          clear   = 1'b1;
          state_d = StLookup;
          owner_d = OwnerFsm;
          ival_d  = int0;
          lat_d   = '0;
        end else if (!req_own) begin
          clear   = 1'b1;
          state_d = StIdle;
        end else if (state_q == StLookup) begin
          if (lat_q == LatLast) begin
            load    = 1'b1;
            state_d = StRun;
          end else begin
            lat_d = lat_q + 2'd1;
          end
        end else if (expire) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    busy_d     = (state_d != StIdle);
    gnt0_d     = busy_d && (owner_d == OwnerFsm);
    gnt1_d     = busy_d && (owner_d == OwnerWalk);
    done0_d    = (state_d == StDone) && (owner_d == OwnerFsm);
    done1_d    = (state_d == StDone) && (owner_d == OwnerWalk);
    abort1_d   = preempt;
    ival_out_d = busy_d ? ival_d : IntMainGreen;
  end

  timer_scheduler_countdown_core #(
    .WIDTH(WIDTH)
  ) u_countdown_core (
    .clk         (clk),
    .Reset_Sync_n(Reset_Sync_n),
    .clear       (clear),
    .load        (load),
    .load_value  (value_in),
    .tick        (dec),
    .remaining   (remaining),
    .expire      (expire)
  );

endmodule

// File: tb/tb_timer_scheduler.sv
// Scoreboarded bench: one LOOKUP_LAT=1 instance for arbitration, one LOOKUP_LAT=3 for latency.
module tb_timer_scheduler;

  logic       clk = 1'b0;
  logic       rst_n, tick, req0, req1, req0_b;
  logic [1:0] int0, int1;
  logic [3:0] vtab [4];

  logic [1:0] ival_a, ival_b, pipe_b1, pipe_b2;
  logic [3:0] value_a, value_b, rem_a, rem_b;
  logic       gnt0_a, gnt1_a, done0_a, done1_a, abort1_a, busy_a;
  logic       gnt0_b, gnt1_b, done0_b, done1_b, abort1_b, busy_b;

  logic [2:0] exp_q [$];
  int         n_vec  = 0;
  int         n_miss = 0;

  always #5 clk = ~clk;

  // Parameter-store model: instant for instance a, two extra register stages for b.
  assign value_a = vtab[ival_a];
  assign value_b = vtab[pipe_b2];
  always @(posedge clk) begin
    pipe_b1 <= ival_b;
    pipe_b2 <= pipe_b1;
  end

  timer_scheduler #(
    .WIDTH     (4),
    .LOOKUP_LAT(1)
  ) dut_a (
    .clk         (clk),
    .Reset_Sync_n(rst_n),
    .oneHz_enable(tick),
    .req0        (req0),
    .int0        (int0),
    .req1        (req1),
    .int1        (int1),
    .value_in    (value_a),
    .interval_out(ival_a),
    .gnt0        (gnt0_a),
    .gnt1        (gnt1_a),
    .done0       (done0_a),
    .done1       (done1_a),
    .abort1      (abort1_a),
    .remaining   (rem_a),
    .busy        (busy_a)
  );

  timer_scheduler #(
    .WIDTH     (4),
    .LOOKUP_LAT(3)
  ) dut_b (
    .clk         (clk),
    .Reset_Sync_n(rst_n),
    .oneHz_enable(tick),
    .req0        (req0_b),
    .int0        (int0),
    .req1        (1'b0),
    .int1        (int1),
    .value_in    (value_b),
    .interval_out(ival_b),
    .gnt0        (gnt0_b),
    .gnt1        (gnt1_b),
    .done0       (done0_b),
    .done1       (done1_b),
    .abort1      (abort1_b),
    .remaining   (rem_b),
    .busy        (busy_b)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  // Pulse monitor: every done/abort pulse on instance a must match the next expected event.
  logic [2:0] ev;
  always @(negedge clk) begin
    ev = {abort1_a, done1_a, done0_a};
    if (rst_n && (ev != 3'b000)) begin
      if (exp_q.size() == 0) check_eq("sb_unexpected", int'(ev), 0);
      else check_eq("sb_event", int'(ev), int'(exp_q.pop_front()));
    end
    if (rst_n) check_eq("gnt_excl", int'(gnt0_a & gnt1_a), 0);
  end

  initial begin
    rst_n = 1'b0; tick = 1'b0; req0 = 1'b0; req1 = 1'b0; req0_b = 1'b0;
    int0 = 2'd0; int1 = 2'd0;
    for (int i = 0; i < 4; i++) vtab[i] = 4'd0;
    step(3);
    check_eq("rst_gnt0", int'(gnt0_a), 0);
    check_eq("rst_busy", int'(busy_a), 0);
    check_eq("rst_rem", int'(rem_a), 0);
    check_eq("rst_ival", int'(ival_a), 0);
    check_eq("rst_busy_b", int'(busy_b), 0);
    rst_n = 1'b1;
    step(1);

    // Basic count of 5 with a tick every 10 cycles
    vtab[2] = 4'd5; int0 = 2'd2; req0 = 1'b1;
    step(1);
    check_eq("s1_gnt0", int'(gnt0_a), 1);
    check_eq("s1_gnt1", int'(gnt1_a), 0);
    check_eq("s1_ival", int'(ival_a), 2);
    step(1);
    check_eq("s1_load", int'(rem_a), 5);
    for (int k = 1; k <= 5; k++) begin
      step(9);
      if (k == 5) exp_q.push_back(3'b001);
      tick_once();
      check_eq("s1_rem", int'(rem_a), 5 - k);
    end
    check_eq("s1_done0", int'(done0_a), 1);
    check_eq("s1_gnt_in_done", int'(gnt0_a), 1);
    req0 = 1'b0;
    step(1);
    check_eq("s1_gnt_off", int'(gnt0_a), 0);
    check_eq("s1_done_off", int'(done0_a), 0);

    // Simultaneous requests: FSM first, walk display after
    vtab[1] = 4'd2; vtab[3] = 4'd1; int0 = 2'd1; int1 = 2'd3;
    req0 = 1'b1; req1 = 1'b1;
    step(1);
    check_eq("s2_gnt0", int'(gnt0_a), 1);
    check_eq("s2_gnt1", int'(gnt1_a), 0);
    step(1);
    tick_once();
    exp_q.push_back(3'b001);
    tick_once();
    check_eq("s2_done0", int'(done0_a), 1);
    req0 = 1'b0;
    step(1);
    check_eq("s2_idle", int'(busy_a), 0);
    step(1);
    check_eq("s2_gnt1", int'(gnt1_a), 1);
    check_eq("s2_ival1", int'(ival_a), 3);
    step(1);
    exp_q.push_back(3'b010);
    tick_once();
    check_eq("s2_done1", int'(done1_a), 1);
    req1 = 1'b0;
    step(1);

    // Pre-emption of the walk count
    vtab[3] = 4'd3; vtab[0] = 4'd6; int1 = 2'd3; int0 = 2'd0; req1 = 1'b1;
    step(2);
    check_eq("s3_rem1", int'(rem_a), 3);
    req0 = 1'b1;
    exp_q.push_back(3'b100);
    step(1);
    check_eq("s3_abort", int'(abort1_a), 1);
    check_eq("s3_gnt0", int'(gnt0_a), 1);
    check_eq("s3_gnt1", int'(gnt1_a), 0);
    check_eq("s3_ival", int'(ival_a), 0);
    step(1);
    check_eq("s3_abort_off", int'(abort1_a), 0);
    check_eq("s3_rem0", int'(rem_a), 6);
    req0 = 1'b0; req1 = 1'b0;
    step(1);
    check_eq("s3_cancel", int'(busy_a), 0);
    check_eq("s3_rem_clr", int'(rem_a), 0);

    // Zero-length interval
    vtab[1] = 4'd0; int0 = 2'd1; req0 = 1'b1;
    step(1);
    check_eq("s4_gnt0", int'(gnt0_a), 1);
    step(1);
    check_eq("s4_no_done", int'(done0_a), 0);
    exp_q.push_back(3'b001);
    step(1);
    check_eq("s4_done0", int'(done0_a), 1);
    req0 = 1'b0;
    step(1);

    // LOOKUP_LAT=3: value must be taken on the third lookup cycle
    vtab[0] = 4'd9; vtab[2] = 4'd2; int0 = 2'd2; req0_b = 1'b1;
    step(1);
    check_eq("s5_gnt0", int'(gnt0_b), 1);
    check_eq("s5_ival", int'(ival_b), 2);
    step(1);
    check_eq("s5_lk1", int'(rem_b), 0);
    step(1);
    check_eq("s5_lk2", int'(rem_b), 0);
    step(1);
    check_eq("s5_load", int'(rem_b), 2);
    tick_once();
    tick_once();
    check_eq("s5_done0", int'(done0_b), 1);
    req0_b = 1'b0;
    step(1);
    check_eq("s5_idle", int'(busy_b), 0);

    // Cancellation, then reset mid-count
    vtab[3] = 4'd4; int1 = 2'd3; req1 = 1'b1;
    step(2);
    check_eq("s6_rem", int'(rem_a), 4);
    req1 = 1'b0;
    step(1);
    check_eq("s6_cancel", int'(busy_a), 0);
    check_eq("s6_gnt1", int'(gnt1_a), 0);
    check_eq("s6_rem_clr", int'(rem_a), 0);
    vtab[2] = 4'd7; int0 = 2'd2; req0 = 1'b1;
    step(2);
    tick_once();
    check_eq("s6_rem_run", int'(rem_a), 6);
    rst_n = 1'b0;
    step(1);
    check_eq("s6_rst_gnt0", int'(gnt0_a), 0);
    check_eq("s6_rst_busy", int'(busy_a), 0);
    check_eq("s6_rst_rem", int'(rem_a), 0);
    check_eq("s6_rst_ival", int'(ival_a), 0);
    req0 = 1'b0; rst_n = 1'b1;
    step(1);
    check_eq("s6_post_rst", int'(busy_a), 0);

    // Tick coinciding with pre-emption is discarded
    vtab[3] = 4'd5; int1 = 2'd3; req1 = 1'b1;
    step(2);
    tick_once();
    check_eq("s7_rem1", int'(rem_a), 4);
    vtab[2] = 4'd3; int0 = 2'd2; req0 = 1'b1; tick = 1'b1;
    exp_q.push_back(3'b100);
    step(1);
    tick = 1'b0; req1 = 1'b0;
    check_eq("s7_abort", int'(abort1_a), 1);
    check_eq("s7_gnt0", int'(gnt0_a), 1);
    step(1);
    check_eq("s7_load", int'(rem_a), 3);
    tick_once();
    check_eq("s7_dec", int'(rem_a), 2);
    tick_once();
    exp_q.push_back(3'b001);
    tick_once();
    check_eq("s7_done0", int'(done0_a), 1);
    check_eq("s7_rem0", int'(rem_a), 0);
    req0 = 1'b0;
    step(2);
    check_eq("s7_idle", int'(busy_a), 0);

    check_eq("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
